pc_unit: RTL and testbench

Next-generation program-counter unit for the fetch stage. It owns the PC register and the exception PC (EPC) register, and computes the next PC each cycle. Next-PC sources are sequential increment, PC-relative branch/jump, register-relative jump, exception vector entry (SIIC) and return-from-exception (RTI). Width, immediate widths, increment and vectors are parametrised, and the block adds stall, halt and nested-exception detection on top of pure next-address arithmetic.

---
 rtl/pc_unit_pkg.sv | 28 ++
 rtl/pc_unit_if.sv | 41 ++++
 rtl/pc_target_calc.sv | 34 +++
 rtl/pc_unit.sv | 146 ++++++++++++++
 tb/tb_pc_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared encodings and default parameters for the program-counter unit.
// Optional build macro used by pc_unit: PC_ALIGN_CHECK_EN.
package pc_unit_pkg;

    localparam int unsigned PC_WIDTH_DEF   = 16;
    localparam int unsigned IMM_I_W_DEF    = 8;
    localparam int unsigned IMM_D_W_DEF    = 11;
    localparam int unsigned INC_DEF        = 2;
    localparam int unsigned RESET_PC_DEF   = 0;
    localparam int unsigned EXC_VECTOR_DEF = 2;

    // redir_kind encoding
    localparam logic [1:0] KIND_BR  = 2'd0;  // PC-relative branch, qualified by taken
    localparam logic [1:0] KIND_JPC = 2'd1;  // PC-relative jump
    localparam logic [1:0] KIND_JRS = 2'd2;  // register-relative jump
    localparam logic [1:0] KIND_RSV = 2'd3;  // reserved, flagged as an error

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    // True when a resolved control-flow instruction actually changes the PC.
    function automatic logic redir_applies(input logic [1:0] kind, input logic taken);
        return (kind == KIND_JPC) || (kind == KIND_JRS) || ((kind == KIND_BR) && taken);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control side bundle of the program-counter unit.
// master drives the control inputs and observes the PC state; slave is the PC unit.
interface pc_unit_if
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = PC_WIDTH_DEF,
    parameter int unsigned IMM_I_W = IMM_I_W_DEF,
    parameter int unsigned IMM_D_W = IMM_D_W_DEF
);
    logic               stall;
    logic               redir_valid;
    logic [1:0]         redir_kind;
    logic               taken;
    logic               sel_d;
    logic [IMM_I_W-1:0] imm_i;
    logic [IMM_D_W-1:0] imm_d;
    logic [WIDTH-1:0]   rs;
    logic               siic;
    logic               rti;
    logic               halt;

    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   pc_plus_inc;
    logic [WIDTH-1:0]   epc;
    logic               in_exc;
    logic               halted;
    logic               err;

    modport master (
        output stall, redir_valid, redir_kind, taken, sel_d, imm_i, imm_d, rs,
               siic, rti, halt,
        input  pc, pc_plus_inc, epc, in_exc, halted, err
    );

    modport slave (
        input  stall, redir_valid, redir_kind, taken, sel_d, imm_i, imm_d, rs,
               siic, rti, halt,
        output pc, pc_plus_inc, epc, in_exc, halted, err
    );

endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect target. Selects and sign-extends the
// displacement, picks the base (pc + INC or rs) and adds modulo 2^WIDTH.
module pc_target_calc
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = PC_WIDTH_DEF,
    parameter int unsigned IMM_I_W = IMM_I_W_DEF,
    parameter int unsigned IMM_D_W = IMM_D_W_DEF
) (
    input  logic [1:0]         kind_i,
    input  logic               sel_d_i,
    input  logic [IMM_I_W-1:0] imm_i_i,
    input  logic [IMM_D_W-1:0] imm_d_i,
    input  logic [WIDTH-1:0]   rs_i,
    input  logic [WIDTH-1:0]   pc_plus_inc_i,
    output logic [WIDTH-1:0]   target_o
);

    logic [WIDTH-1:0] ext_i;
    logic [WIDTH-1:0] ext_d;
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] base;

    assign ext_i = {{(WIDTH-IMM_I_W){imm_i_i[IMM_I_W-1]}}, imm_i_i};
    assign ext_d = {{(WIDTH-IMM_D_W){imm_d_i[IMM_D_W-1]}}, imm_d_i};

    // Displacement/base select and the wrapping adder.
    always_comb begin
        ext      = sel_d_i ? ext_d : ext_i;
        base     = (kind_i == KIND_JRS) ? rs_i : pc_plus_inc_i;
        target_o = base + ext;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with exception PC, stall, halt and
// nested-exception detection.
// Optional build macro: PC_ALIGN_CHECK_EN -- odd redirect targets raise an
// exception instead of being loaded.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | normal next-PC selection every cycle
// ST_HALT | pc/epc/in_exc frozen, inputs ignored, left only through rst
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = PC_WIDTH_DEF,
    parameter int unsigned IMM_I_W    = IMM_I_W_DEF,
    parameter int unsigned IMM_D_W    = IMM_D_W_DEF,
    parameter int unsigned INC        = INC_DEF,
    parameter int unsigned RESET_PC   = RESET_PC_DEF,
    parameter int unsigned EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    localparam logic [WIDTH-1:0] PC_RST  = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] PC_EXC  = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INC);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             in_exc_q, in_exc_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] pc_plus_inc;
    logic [WIDTH-1:0] target;
    logic             redir_take;
    logic             redir_rsv;

    assign pc_plus_inc = pc_q + PC_STEP;
    assign redir_take  = bus.redir_valid && redir_applies(bus.redir_kind, bus.taken);
    assign redir_rsv   = bus.redir_valid && (bus.redir_kind == KIND_RSV);

    pc_target_calc #(
        .WIDTH   (WIDTH),
        .IMM_I_W (IMM_I_W),
        .IMM_D_W (IMM_D_W)
    ) u_target (
        .kind_i        (bus.redir_kind),
        .sel_d_i       (bus.sel_d),
        .imm_i_i       (bus.imm_i),
        .imm_d_i       (bus.imm_d),
        .rs_i          (bus.rs),
        .pc_plus_inc_i (pc_plus_inc),
        .target_o      (target)
    );

    // Next-state selection; halt beats exception beats return beats redirect beats stall.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        in_exc_d = in_exc_q;
        halted_d = halted_q;
        err_d    = err_q;

        if (state_q == ST_RUN) begin
            if (bus.halt) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
            end else if (bus.siic) begin
                if (!in_exc_q) begin
                    epc_d    = pc_plus_inc;
                    pc_d     = PC_EXC;
                    in_exc_d = 1'b1;
                end else begin
                    // Exception inside the handler cannot be unwound: stop the core.
                    err_d    = 1'b1;
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end else if (bus.rti && in_exc_q) begin
                pc_d     = epc_q;
                in_exc_d = 1'b0;
            end else begin
                // A stray rti is flagged but does not block the rest of the cycle.
                if (bus.rti) begin
                    err_d = 1'b1;
                end

                if (redir_take) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (target[0]) begin
                        if (!in_exc_q) begin
                            epc_d    = pc_plus_inc;
                            pc_d     = PC_EXC;
                            in_exc_d = 1'b1;
                        end else begin
                            err_d    = 1'b1;
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end
                    end else begin
                        pc_d = target;
                    end
`else
                    pc_d = target;
`endif
                end else if (redir_rsv) begin
                    err_d = 1'b1;
                    pc_d  = pc_plus_inc;
                end else if (!bus.stall) begin
                    pc_d = pc_plus_inc;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= PC_RST;
            epc_q    <= '0;
            in_exc_q <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            in_exc_q <= in_exc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_plus_inc;
    assign bus.epc         = epc_q;
    assign bus.in_exc      = in_exc_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table for pc_unit (default parameters), followed
// by hand-written increment and halt-freeze sequences.
module tb_pc_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pc_unit_if #(.WIDTH(16), .IMM_I_W(8), .IMM_D_W(11)) bus ();

    pc_unit #(
        .WIDTH      (16),
        .IMM_I_W    (8),
        .IMM_D_W    (11),
        .INC        (2),
        .RESET_PC   (0),
        .EXC_VECTOR (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        stall;
        bit        rv;
        bit [1:0]  kind;
        bit        taken;
        bit        sel_d;
        bit [7:0]  imm_i;
        bit [10:0] imm_d;
        bit [15:0] rs;
        bit        siic;
        bit        rti;
        bit        halt;
        bit [15:0] e_pc;
        bit [15:0] e_epc;
        bit        e_in_exc;
        bit        e_halted;
        bit        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input bit r, input bit st, input bit rv, input bit [1:0] k, input bit tk,
        input bit sd, input bit [7:0] ii, input bit [10:0] id, input bit [15:0] rs,
        input bit si, input bit rt, input bit hl,
        input bit [15:0] pc, input bit [15:0] epc, input bit ie, input bit hd, input bit er);
        vec_t v;
        v.rst = r; v.stall = st; v.rv = rv; v.kind = k; v.taken = tk; v.sel_d = sd;
        v.imm_i = ii; v.imm_d = id; v.rs = rs; v.siic = si; v.rti = rt; v.halt = hl;
        v.e_pc = pc; v.e_epc = epc; v.e_in_exc = ie; v.e_halted = hd; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst             = v.rst;
        bus.stall       = v.stall;
        bus.redir_valid = v.rv;
        bus.redir_kind  = v.kind;
        bus.taken       = v.taken;
        bus.sel_d       = v.sel_d;
        bus.imm_i       = v.imm_i;
        bus.imm_d       = v.imm_d;
        bus.rs          = v.rs;
        bus.siic        = v.siic;
        bus.rti         = v.rti;
        bus.halt        = v.halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] pc, input logic [15:0] epc,
                               input logic ie, input logic hd, input logic er);
        chk({tag, "_pc"},     bus.pc,          pc);
        chk({tag, "_pcinc"},  bus.pc_plus_inc, pc + 16'd2);
        chk({tag, "_epc"},    bus.epc,         epc);
        chk({tag, "_in_exc"}, 16'(bus.in_exc), 16'(ie));
        chk({tag, "_halted"}, 16'(bus.halted), 16'(hd));
        chk({tag, "_err"},    16'(bus.err),    16'(er));
    endtask

    vec_t idle;

    initial begin
        checks   = 0;
        failures = 0;
        idle = mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0,16'h0,0,0,0);
        drive(idle);
        rst = 1'b1;

        //          rst st rv kind tk sd imm_i  imm_d    rs        si rt hl  pc        epc       ie hd er
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0000,16'h0000,0,0,0)); // reset
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0002,16'h0000,0,0,0)); // inc
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0004,16'h0000,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0006,16'h0000,0,0,0));
        vq.push_back(mk(0,0,1,2'd2,0,0,8'h00,11'h000,16'h0010,0,0,0, 16'h0010,16'h0000,0,0,0)); // jrs to 0x10
        vq.push_back(mk(0,0,1,2'd0,1,0,8'hFC,11'h000,16'h0000,0,0,0, 16'h000E,16'h0000,0,0,0)); // br taken -4
        vq.push_back(mk(0,0,1,2'd2,0,0,8'h00,11'h000,16'h0010,0,0,0, 16'h0010,16'h0000,0,0,0));
        vq.push_back(mk(0,0,1,2'd0,0,0,8'hFC,11'h000,16'h0000,0,0,0, 16'h0012,16'h0000,0,0,0)); // br not taken
        vq.push_back(mk(0,0,1,2'd2,0,0,8'h00,11'h000,16'h0010,0,0,0, 16'h0010,16'h0000,0,0,0));
        vq.push_back(mk(0,1,1,2'd0,0,0,8'hFC,11'h000,16'h0000,0,0,0, 16'h0010,16'h0000,0,0,0)); // stall + nt
        vq.push_back(mk(0,1,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0010,16'h0000,0,0,0)); // stall
        vq.push_back(mk(0,0,1,2'd1,0,1,8'h00,11'h400,16'h0000,0,0,0, 16'hFC12,16'h0000,0,0,0)); // jpc imm_d -1024
        vq.push_back(mk(0,0,1,2'd1,0,0,8'h7F,11'h000,16'h0000,0,0,0, 16'hFC93,16'h0000,0,0,0)); // jpc +127, odd
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'hFC95,16'h0000,0,0,0));
        vq.push_back(mk(0,0,1,2'd2,0,0,8'h04,11'h000,16'hFFFE,0,0,0, 16'h0002,16'h0000,0,0,0)); // jrs wrap
        vq.push_back(mk(0,0,1,2'd2,0,0,8'h00,11'h000,16'h0100,0,0,0, 16'h0100,16'h0000,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,1,0,0, 16'h0002,16'h0102,1,0,0)); // siic
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,1,0, 16'h0102,16'h0102,0,0,0)); // rti
        vq.push_back(mk(0,1,1,2'd2,0,1,8'h00,11'h010,16'h0200,0,0,0, 16'h0210,16'h0102,0,0,0)); // jrs imm_d over stall
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,1,0,0, 16'h0002,16'h0212,1,0,0)); // siic
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,1,0,0, 16'h0002,16'h0212,1,1,1)); // nested
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,1,0, 16'h0002,16'h0212,1,1,1)); // frozen x5
        vq.push_back(mk(0,0,1,2'd2,0,0,8'h00,11'h000,16'h0040,0,0,0, 16'h0002,16'h0212,1,1,1));
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0002,16'h0212,1,1,1));
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,1,0,0, 16'h0002,16'h0212,1,1,1));
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,1, 16'h0002,16'h0212,1,1,1));
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0000,16'h0000,0,0,0)); // rst from halt
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,1,0, 16'h0002,16'h0000,0,0,1)); // stray rti
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0004,16'h0000,0,0,1)); // err sticky
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0000,16'h0000,0,0,0));
        vq.push_back(mk(0,0,1,2'd3,1,0,8'h20,11'h000,16'h0000,0,0,0, 16'h0002,16'h0000,0,0,1)); // reserved kind
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0000,16'h0000,0,0,0));
        vq.push_back(mk(0,0,1,2'd1,0,0,8'h08,11'h000,16'h0000,0,1,0, 16'h000A,16'h0000,0,0,1)); // stray rti + jpc
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0000,16'h0000,0,0,0));
        vq.push_back(mk(0,1,1,2'd1,0,0,8'h10,11'h000,16'h0000,1,0,0, 16'h0002,16'h0002,1,0,0)); // siic+redir+stall
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,1,0, 16'h0002,16'h0002,0,0,0)); // rti
        vq.push_back(mk(0,1,1,2'd1,0,0,8'h10,11'h000,16'h0000,1,0,1, 16'h0002,16'h0002,0,1,0)); // halt wins
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,1,0, 16'h0002,16'h0002,0,1,0));
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0000,16'h0000,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,1,0,0, 16'h0002,16'h0002,1,0,0)); // siic
        vq.push_back(mk(1,0,0,2'd0,0,0,8'h00,11'h000,16'h0000,1,1,0, 16'h0000,16'h0000,0,0,0)); // rst mid-exc
        vq.push_back(mk(0,1,1,2'd3,0,0,8'h00,11'h000,16'h0000,0,0,0, 16'h0002,16'h0000,0,0,1)); // rsv over stall

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            tick();
            check_state($sformatf("v%0d", i), vq[i].e_pc, vq[i].e_epc,
                        vq[i].e_in_exc, vq[i].e_halted, vq[i].e_err);
        end

        // Plain increment run from reset.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        tick();
        check_state("seq_rst", 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("seq_inc%0d", i), bus.pc, 16'(2 * i));
        end

        // Halt, then hammer inputs: nothing may move.
        @(negedge clk);
        bus.halt = 1'b1;
        tick();
        check_state("seq_halt", 16'h0010, 16'h0000, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.halt        = 1'($urandom_range(0, 1));
            bus.stall       = 1'($urandom_range(0, 1));
            bus.redir_valid = 1'b1;
            bus.redir_kind  = 2'($urandom_range(0, 3));
            bus.taken       = 1'b1;
            bus.imm_i       = 8'($urandom);
            bus.rs          = 16'($urandom);
            bus.siic        = 1'($urandom_range(0, 1));
            bus.rti         = 1'($urandom_range(0, 1));
            tick();
            check_state($sformatf("seq_frz%0d", i), 16'h0010, 16'h0000, 0, 1, 0);
        end

        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        tick();
        check_state("seq_rst2", 16'h0000, 16'h0000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
